// File: rtl/sha256_padder_if.sv
// -----------------------------------------------------------------------------
// sha256_padder_if
//   Bundles the byte-stream input and the compression-core handshake of the
//   SHA-256 padder.
//   Byte stream : in_data, in_valid, in_last, in_empty (to padder), in_ready
//   Core side   : block_out, core_start, core_first_run (to core), core_ready
//   Status      : done, busy
//   slave  : seen from the padder
//   master : seen from the feeder / core / testbench
// -----------------------------------------------------------------------------
interface sha256_padder_if;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_empty;
    logic         in_ready;
    logic [511:0] block_out;
    logic         core_start;
    logic         core_first_run;
    logic         core_ready;
    logic         done;
    logic         busy;

    modport slave (
        input  in_data, in_valid, in_last, in_empty, core_ready,
        output in_ready, block_out, core_start, core_first_run, done, busy
    );

    modport master (
        output in_data, in_valid, in_last, in_empty, core_ready,
        input  in_ready, block_out, core_start, core_first_run, done, busy
    );
endinterface

// File: rtl/sha256_padder.sv
// -----------------------------------------------------------------------------
// sha256_padder
//   Packs a byte stream big-endian into 512-bit blocks, applies SHA-256
//   padding (0x80, zero fill, 64-bit big-endian bit length) and hands each
//   block to the compression core with a level start / first_run handshake.
//   done pulses for one cycle when the core holds the digest of the final
//   block of a message.
//
//   Ports:
//     clk    : clock
//     rst_n  : asynchronous active-low reset (core must be reset together)
//     bus    : sha256_padder_if.slave (byte stream in, core handshake out,
//              done/busy status)
//   Parameter:
//     CNT_W  : width of the message byte counter (wraps silently)
// -----------------------------------------------------------------------------
module sha256_padder #(
    parameter int unsigned CNT_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    sha256_padder_if.slave bus
);

    typedef enum logic [2:0] {
        ABSORB,
        FINAL,
        SEND,
        WAIT_CLR,
        WAIT_SET,
        RELEASE,
        PAD2
    } state_t;

    state_t           state;
    logic [511:0]     blk;
    logic [6:0]       idx;           // bytes held in the current block, 0..64
    logic [CNT_W-1:0] cnt;           // message length in bytes
    logic             final_blk;     // block in flight is the last of the message
    logic             pad2_pending;  // an extra length-only block must follow
    logic             pad2_marker;   // that extra block starts with 0x80
    logic             in_ready_q;
    logic             core_start_q;
    logic             first_run_q;
    logic             done_q;
    logic             busy_q;

    logic [63:0]      bit_len;
    logic [9:0]       shamt;
    logic [511:0]     tail_mask;
    logic [511:0]     marker;
    logic [511:0]     final_pad;
    logic [511:0]     pad2_blk;
    logic             accept;

    assign accept  = bus.in_valid && in_ready_q;
    assign bit_len = 64'(cnt) << 3;

    // Bytes idx..63 of the block; with idx = 64 the shift empties both masks,
    // so a full block passes through FINAL untouched.
    assign shamt     = {idx, 3'b000};
    assign tail_mask = '1 >> shamt;
    assign marker    = {8'h80, 504'd0} >> shamt;

    always_comb begin
        final_pad = (blk & ~tail_mask) | marker;
        if (idx <= 7'd55) begin
            final_pad[63:0] = bit_len;
        end
    end

    assign pad2_blk = {(pad2_marker ? 8'h80 : 8'h00), 440'd0, bit_len};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ABSORB;
            blk          <= '0;
            idx          <= '0;
            cnt          <= '0;
            final_blk    <= 1'b0;
            pad2_pending <= 1'b0;
            pad2_marker  <= 1'b0;
            in_ready_q   <= 1'b1;
            core_start_q <= 1'b0;
            first_run_q  <= 1'b1;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ABSORB: begin
                    if (accept) begin
                        busy_q <= 1'b1;
                        if (bus.in_empty) begin
                            state      <= FINAL;
                            in_ready_q <= 1'b0;
                        end else begin
                            blk[9'd511 - {idx[5:0], 3'b000} -: 8] <= bus.in_data;
                            idx <= idx + 7'd1;
                            cnt <= cnt + 1'b1;
                            if (bus.in_last) begin
                                state      <= FINAL;
                                in_ready_q <= 1'b0;
                            end else if (idx == 7'd63) begin
                                state        <= SEND;
                                final_blk    <= 1'b0;
                                core_start_q <= 1'b1;
                                in_ready_q   <= 1'b0;
                            end
                        end
                    end
                end

                FINAL: begin
                    blk          <= final_pad;
                    core_start_q <= 1'b1;
                    state        <= SEND;
                    if (idx <= 7'd55) begin
                        final_blk <= 1'b1;
                    end else begin
                        // No room for the length: it goes in a second block,
                        // which carries the 0x80 only if this one is full.
                        final_blk    <= 1'b0;
                        pad2_pending <= 1'b1;
                        pad2_marker  <= (idx == 7'd64);
                    end
                end

                // core_ready may still be high from the previous block here.
                SEND: state <= WAIT_CLR;

                WAIT_CLR: begin
                    if (!bus.core_ready) begin
                        state <= WAIT_SET;
                    end
                end

                WAIT_SET: begin
                    if (bus.core_ready) begin
                        core_start_q <= 1'b0;
                        first_run_q  <= 1'b0;
                        state        <= RELEASE;
                        if (final_blk) begin
                            done_q      <= 1'b1;
                            idx         <= '0;
                            cnt         <= '0;
                            first_run_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end
                    end
                end

                RELEASE: begin
                    if (pad2_pending) begin
                        state <= PAD2;
                    end else begin
                        state      <= ABSORB;
                        in_ready_q <= 1'b1;
                        final_blk  <= 1'b0;
                        if (!final_blk) begin
                            idx <= '0;
                            blk <= '0;
                        end
                    end
                end

                PAD2: begin
                    blk          <= pad2_blk;
                    pad2_pending <= 1'b0;
                    final_blk    <= 1'b1;
                    core_start_q <= 1'b1;
                    state        <= SEND;
                end

                default: state <= ABSORB;
            endcase
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.block_out      = blk;
    assign bus.core_start     = core_start_q;
    assign bus.core_first_run = first_run_q;
    assign bus.done           = done_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_sha256_padder.sv
// -----------------------------------------------------------------------------
// tb_sha256_padder
//   Directed bench for sha256_padder: a table of messages with hand-computed
//   block words, a behavioural compression-core handshake model that records
//   every block it is started on, and a reset-in-flight sequence.
// -----------------------------------------------------------------------------
module tb_sha256_padder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sha256_padder_if bus();

    sha256_padder #(.CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int unsigned len;
        int unsigned base;
        int unsigned step;
        int unsigned term;      // 0: in_last on final byte, 1: in_empty beat, 2: in_empty+in_last beat
        int unsigned nblk;
        logic [31:0] w0_first;
        logic [31:0] w0_last;
        logic [31:0] w15_last;
    } vec_t;

    typedef enum {C_IDLE, C_BUSY, C_DONE} cstate_t;

    int           checks   = 0;
    int           failures = 0;
    logic [511:0] cap_blk[$];
    bit           cap_fr[$];
    int unsigned  done_cnt = 0;
    int unsigned  stab_err = 0;
    int unsigned  rdy_err  = 0;
    int unsigned  rel_err  = 0;
    int unsigned  core_lat_min = 2;
    int unsigned  core_lat_max = 6;
    cstate_t      cst = C_IDLE;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Compression-core handshake model: idle with ready=1, drops ready while
    // hashing, raises ready and holds it until start is released.
    initial begin
        int unsigned  lat     = 0;
        logic [511:0] held    = '0;
        bit           rel_chk = 1'b0;
        bus.core_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                cst            = C_IDLE;
                bus.core_ready = 1'b1;
                rel_chk        = 1'b0;
            end else begin
                if (bus.done) done_cnt++;
                if (bus.core_start && bus.in_ready) rdy_err++;
                if (rel_chk && bus.core_start) rel_err++;
                rel_chk = 1'b0;
                case (cst)
                    C_IDLE: begin
                        if (bus.core_start) begin
                            cap_blk.push_back(bus.block_out);
                            cap_fr.push_back(bus.core_first_run);
                            held           = bus.block_out;
                            lat            = $urandom_range(core_lat_max, core_lat_min);
                            bus.core_ready = 1'b0;
                            cst            = C_BUSY;
                        end
                    end
                    C_BUSY: begin
                        if (bus.block_out !== held) stab_err++;
                        lat--;
                        if (lat == 0) begin
                            bus.core_ready = 1'b1;
                            cst            = C_DONE;
                        end
                    end
                    default: begin
                        if (bus.core_start) begin
                            if (bus.block_out !== held) stab_err++;
                        end else begin
                            cst     = C_IDLE;
                            rel_chk = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Called just after a falling edge; returns just after the falling edge
    // following acceptance.
    task automatic send_beat(input logic [7:0] d, input bit last, input bit empty);
        int unsigned guard = 0;
        bus.in_valid = 1'b0;
        repeat ($urandom_range(2, 0)) @(negedge clk);
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_empty = empty;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            checks++;
            failures++;
            $display("FAIL beat_accept_timeout actual=in_ready_low required=in_ready_high");
        end else begin
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_empty = 1'b0;
    endtask

    task automatic send_msg(input vec_t v, output logic [7:0] msg[$]);
        msg.delete();
        for (int unsigned i = 0; i < v.len; i++) msg.push_back(8'(v.base + i * v.step));
        for (int unsigned i = 0; i < v.len; i++)
            send_beat(msg[i], (v.term == 0) && (i == v.len - 1), 1'b0);
        if (v.len == 0 || v.term == 1) send_beat(8'h00, 1'b0, 1'b1);
        else if (v.term == 2)          send_beat(8'hFF, 1'b1, 1'b1);
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        logic [7:0]   msg[$];
        logic [7:0]   pad[$];
        logic [63:0]  bl;
        logic [511:0] exp_blk;
        int unsigned  guard = 0;

        cap_blk.delete();
        cap_fr.delete();
        done_cnt = 0;

        send_msg(v, msg);
        check($sformatf("v%0d_busy_after_last", vi), bus.busy, 1'b1);

        while (done_cnt == 0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        repeat (10) @(negedge clk);
        check($sformatf("v%0d_done_pulses", vi), done_cnt, 1);
        check($sformatf("v%0d_busy_after_done", vi), bus.busy, 1'b0);
        check($sformatf("v%0d_nblk", vi), cap_blk.size(), v.nblk);

        // Reference padding built byte-wise from the message.
        pad = msg;
        pad.push_back(8'h80);
        while (pad.size() % 64 != 56) pad.push_back(8'h00);
        bl = 64'(v.len) * 64'd8;
        for (int k = 7; k >= 0; k--) pad.push_back(bl[8*k +: 8]);

        for (int unsigned b = 0; b < v.nblk; b++) begin
            exp_blk = '0;
            for (int unsigned j = 0; j < 64; j++) exp_blk[511 - 8*j -: 8] = pad[64*b + j];
            if (b < cap_blk.size()) begin
                check($sformatf("v%0d_blk%0d", vi, b), cap_blk[b], exp_blk);
                check($sformatf("v%0d_first_run%0d", vi, b), cap_fr[b], (b == 0));
            end
        end

        if (cap_blk.size() > 0) begin
            check($sformatf("v%0d_w0_first", vi), cap_blk[0][511:480], v.w0_first);
            check($sformatf("v%0d_w0_last", vi), cap_blk[cap_blk.size()-1][511:480], v.w0_last);
            check($sformatf("v%0d_w15_last", vi), cap_blk[cap_blk.size()-1][31:0], v.w15_last);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[10];
        logic [7:0]  msg[$];
        vec_t        rv;
        int unsigned guard;

        vecs[0] = '{3,   'h61, 1, 0, 1, 32'h61626380, 32'h61626380, 32'h00000018};
        vecs[1] = '{0,   'h00, 0, 1, 1, 32'h80000000, 32'h80000000, 32'h00000000};
        vecs[2] = '{55,  'h61, 0, 0, 1, 32'h61616161, 32'h61616161, 32'h000001B8};
        vecs[3] = '{56,  'h61, 0, 0, 2, 32'h61616161, 32'h00000000, 32'h000001C0};
        vecs[4] = '{64,  'h61, 0, 0, 2, 32'h61616161, 32'h80000000, 32'h00000200};
        vecs[5] = '{64,  'h00, 1, 1, 2, 32'h00010203, 32'h80000000, 32'h00000200};
        vecs[6] = '{3,   'h61, 1, 2, 1, 32'h61626380, 32'h61626380, 32'h00000018};
        vecs[7] = '{200, 'h00, 1, 0, 4, 32'h00010203, 32'hC0C1C2C3, 32'h00000640};
        vecs[8] = '{120, 'h00, 1, 0, 3, 32'h00010203, 32'h00000000, 32'h000003C0};
        vecs[9] = '{63,  'h10, 1, 0, 2, 32'h10111213, 32'h00000000, 32'h000001F8};

        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_empty = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_in_ready",   bus.in_ready,       1'b1);
        check("rst_block_out",  bus.block_out,      '0);
        check("rst_core_start", bus.core_start,     1'b0);
        check("rst_first_run",  bus.core_first_run, 1'b1);
        check("rst_done",       bus.done,           1'b0);
        check("rst_busy",       bus.busy,           1'b0);

        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 10; v++) run_vec(vecs[v], v);

        // Reset while the core is hashing block 2 of a 100-byte message.
        core_lat_min = 10;
        core_lat_max = 10;
        cap_blk.delete();
        cap_fr.delete();
        rv = '{100, 'h5A, 0, 0, 2, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h00000320};
        send_msg(rv, msg);
        guard = 0;
        while (!(cap_blk.size() == 2 && cst == C_BUSY) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        check("pre_reset_start",     bus.core_start,     1'b1);
        check("pre_reset_first_run", bus.core_first_run, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_block_out",  bus.block_out,      '0);
        check("mid_rst_core_start", bus.core_start,     1'b0);
        check("mid_rst_first_run",  bus.core_first_run, 1'b1);
        check("mid_rst_done",       bus.done,           1'b0);
        check("mid_rst_busy",       bus.busy,           1'b0);
        check("mid_rst_in_ready",   bus.in_ready,       1'b1);
        repeat (2) @(negedge clk);
        rst_n        = 1'b1;
        core_lat_min = 2;
        core_lat_max = 6;
        @(negedge clk);
        run_vec(vecs[0], 10);

        check("block_stable_while_start", stab_err, 0);
        check("in_ready_low_while_start", rdy_err,  0);
        check("start_low_after_release",  rel_err,  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha256_padder.md
Name: sha256_padder

Overview:
Upstream feeder for the SHA-256 compression core. Accepts a message as a byte stream, packs bytes big-endian into 512-bit blocks and applies FIPS 180-4 padding (0x80, zero fill, 64-bit big-endian bit length). Presents each block to the core with a level start / first_run handshake, sequences multi-block messages, and pulses done when the core holds the final digest.

Parameters:
CNT_W, 32, width of the message byte counter. Bit length = {count, 3'b000}, zero-extended to 64 bits. Messages of 2^CNT_W bytes or more are unsupported.

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock domain, asynchronous assert, active-low
in_data  in  8  message byte
in_valid  in  1  in_data or in_empty qualifier
in_last  in  1  with in_valid: in_data is the final message byte
in_empty  in  1  with in_valid: end of message, no byte carried (zero-length message or terminator); in_data and in_last are ignored
in_ready  out  1  byte accepted when in_valid && in_ready
block_out  out  512  block to core; byte 0 at [511:504]
core_start  out  1  level start to core
core_first_run  out  1  1 for the first block of a message, else 0
core_ready  in  1  core ready flag
done  out  1  one-cycle pulse: core hash_out valid for this message
busy  out  1  high from the first accepted beat until done

Behaviour:
- Reset (rst_n low, async): state ABSORB; block_out=0; core_start=0; core_first_run=1; done=0; busy=0; in_ready=1; byte index and counters cleared. A reset mid-message discards the message. Core must be reset at the same time.
- States: ABSORB, FINAL, SEND, WAIT_CLR, WAIT_SET, RELEASE, PAD2.
- ABSORB: in_ready=1. Each accepted byte goes into block byte idx (0..63); idx increments; the length counter increments.
  - Byte 64 without in_last -> SEND, block not final.
  - Byte with in_last, or in_empty -> FINAL; in_ready drops the next cycle.
- FINAL (one cycle), with n = bytes in the current block (0..64):
  - n<=55: byte n=0x80, zeros, bytes 56..63 = bit length -> SEND, final.
  - 56<=n<=63: byte n=0x80, rest zero -> SEND, not final, pad2_pending with no leading marker.
  - n=64: block unchanged -> SEND, not final, pad2_pending with leading marker.
- SEND: core_start=1 and block_out/core_first_run stable. Next cycle -> WAIT_CLR. A stale core_ready=1 is ignored in this cycle.
- WAIT_CLR: hold start until core_ready==0 -> WAIT_SET.
- WAIT_SET: hold start until core_ready==1. Then:
  - core_start=0 and core_first_run=0 next cycle.
  - final block: done=1 for one cycle, counters cleared, core_first_run=1, busy=0, -> RELEASE.
  - otherwise -> RELEASE.
- RELEASE (one cycle, lets the core return to IDLE):
  - pad2_pending -> PAD2.
  - last block of message -> ABSORB.
  - otherwise -> ABSORB with idx=0 and block cleared.
- PAD2 (one cycle): block = [0x80 if leading marker else 0x00], zeros, length in bytes 56..63 -> SEND, final.
- in_ready=0 in every state except ABSORB. block_out changes only in ABSORB/FINAL/PAD2, never while core_start=1.
- Byte counter wraps silently at 2^CNT_W.
- in_last and in_empty both set: in_empty wins.

Test Plan:
- "abc" (0x61,0x62,0x63 with in_last) -> one block: word0=0x61626380, words1-14=0, word15=0x00000018; first_run=1; digest ba7816bf...f20015ad; done pulses once.
- in_empty only -> block 0x80000000 followed by zeros, length 0; digest e3b0c442...7852b855.
- 55 bytes 0x61 -> exactly one block, length 0x1B8. 56 bytes -> two blocks: first ends 0x80 then zeros; second all zero except length 0x1C0; first_run 1 then 0.
- 64 bytes -> two blocks: second word0=0x80000000, word15=0x00000200; digest matches reference model.
- Random in_valid gaps, 200-byte message -> 4 blocks; in_ready=0 outside ABSORB; digest matches model; core_start never high during RELEASE.
- rst_n low during WAIT_SET of block 2 -> all outputs at reset values immediately; a new "abc" message afterwards gives the correct digest.
